// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit command, hazard and HI/LO result signals.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             read_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, read_req,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, read_req,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers and a
// stall request for the pipeline hazard logic. One result bit per clock.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic     i_clk,
  input logic     i_reset,
  muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_divz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_busy;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_is_arith;
  logic               w_is_mt;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_trial;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Command decode and operand magnitudes (op[0] set = unsigned variant).
  always_comb begin
    w_is_arith = ~bus.op[2];
    w_is_mt    = bus.op[2] & ~bus.op[1];
    w_signed   = ~bus.op[0];
    w_sa       = w_signed & bus.src_a[WIDTH-1];
    w_sb       = w_signed & bus.src_b[WIDTH-1];
    w_mag_a    = w_sa ? -bus.src_a : bus.src_a;
    w_mag_b    = w_sb ? -bus.src_b : bus.src_b;
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  always_comb begin
    w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    w_ge      = w_rem_sh >= {1'b0, r_opnd};
    w_trial   = w_rem_sh[WIDTH-1:0] - r_opnd;
    w_div_acc = {(w_ge ? w_trial : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_prod = r_neg_lo ? -r_acc : r_acc;
    w_quo  = r_acc[WIDTH-1:0];
    w_rem  = r_acc[2*WIDTH-1:WIDTH];
    if (r_divz)        w_quo = '1;
    else if (r_neg_lo) w_quo = -r_acc[WIDTH-1:0];
    if (r_neg_hi)      w_rem = -r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_divz   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_is_mt) begin
            if (bus.op[0]) r_lo <= bus.src_a;
            else           r_hi <= bus.src_a;
          end else if (bus.start && w_is_arith) begin
            r_is_div <= bus.op[1];
            r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
            r_opnd   <= bus.op[1] ? w_mag_b : w_mag_a;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= bus.op[1] & w_sa;
            r_divz   <= bus.op[1] & (bus.src_b == '0);
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          if (r_is_div) begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy    = (r_state != S_IDLE);
  assign bus.busy  = w_busy;
  assign bus.stall = w_busy & (bus.start | bus.read_req);
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed test of muldiv_unit: arithmetic results, timing, hazards, MTHI/MTLO, reset abort.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Bounded wait for the done pulse; leaves time in the FIN cycle.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) break;
      tick();
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_done(tag);
    tick();
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = OP_NOP;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.read_req = 1'b0;
    tick();
    tick();
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // MULTU latency: busy t+1..t+33, done in FIN cycle only
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("mu_busy_t1", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 31; i++) tick();
    check("mu_done_early", 64'(bus.done), 64'd0);
    check("mu_busy_t31", 64'(bus.busy), 64'd1);
    tick();
    check("mu_done_fin", 64'(bus.done), 64'd1);
    check("mu_busy_fin", 64'(bus.busy), 64'd1);
    tick();
    check("mu_done_after", 64'(bus.done), 64'd0);
    check("mu_busy_after", 64'(bus.busy), 64'd0);
    check("mu_hi", 64'(bus.hi), 64'h1);
    check("mu_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_big", OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("mult_mixed", OP_MULT, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);

    // Hazards: read_req and a second start while busy
    issue(OP_DIVU, 32'd100, 32'd7);
    bus.read_req = 1'b1;
    #1;
    check("hz_rd_stall0", 64'(bus.stall), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("hz_rd_stall5", 64'(bus.stall), 64'd1);
    check("hz_hi_hold", 64'(bus.hi), 64'hFFFF_FFFF);
    bus.read_req = 1'b0;
    #1;
    check("hz_nostall", 64'(bus.stall), 64'd0);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    #1;
    check("hz_st_stall", 64'(bus.stall), 64'd1);
    wait_done("hz_div");
    check("hz_st_stall_fin", 64'(bus.stall), 64'd1);
    tick();
    check("hz_wb_busy", 64'(bus.busy), 64'd0);
    check("hz_wb_stall", 64'(bus.stall), 64'd0);
    check("hz_wb_lo", 64'(bus.lo), 64'd14);
    check("hz_wb_hi", 64'(bus.hi), 64'd2);
    bus.read_req = 1'b1;
    #1;
    check("hz_wb_rd_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.start    = 1'b0;
    bus.read_req = 1'b0;
    check("hz_acc_busy", 64'(bus.busy), 64'd1);
    wait_done("hz_mul");
    tick();
    check("hz_mul_lo", 64'(bus.lo), 64'd42);
    check("hz_mul_hi", 64'(bus.hi), 64'd0);

    // MTHI then MTLO back to back
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi_lo", 64'(bus.lo), 64'd42);
    check("mthi_done", 64'(bus.done), 64'd0);
    issue(OP_MTLO, 32'hCAFE_BABE, 32'd0);
    check("mtlo_lo", 64'(bus.lo), 64'hCAFE_BABE);
    check("mtlo_hi", 64'(bus.hi), 64'h1234_5678);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check("mtlo_done", 64'(bus.done), 64'd0);

    // No-op code: nothing changes
    issue(OP_NOP, 32'hDEAD_BEEF, 32'd3);
    check("nop_busy", 64'(bus.busy), 64'd0);
    check("nop_hilo", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_BABE);

    // Reset at counter=10 of a DIV aborts and clears HI/LO
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.read_req = 1'b1;
    #1;
    check("rstm_busy", 64'(bus.busy), 64'd0);
    check("rstm_stall", 64'(bus.stall), 64'd0);
    check("rstm_hi", 64'(bus.hi), 64'd0);
    check("rstm_lo", 64'(bus.lo), 64'd0);
    bus.read_req = 1'b0;
    run_op("post_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
